// File: rtl/vx_hpdcache_tid_pkg.sv
// Shared types and sizing helpers for the HPDCache tid remapping stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vx_hpdcache_tid_pkg;

  localparam int DEF_ADDR_WIDTH     = 26;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_CORE_TAG_WIDTH = 16;
  localparam int DEF_TID_WIDTH      = 3;

  // Types for the default configuration; the top rebuilds the entry layout
  // from its own parameters so non-default widths stay consistent.
  typedef logic [DEF_TID_WIDTH-1:0] tid_t;

  typedef struct packed {
    tid_t                          tid;
    logic [DEF_CORE_TAG_WIDTH-1:0] tag;
    logic [DEF_DATA_WIDTH-1:0]     data;
  } rsp_entry_t;

  // Number of concurrently outstanding loads addressable by a tid field.
  function automatic int num_tids(input int tid_width);
    return 1 << tid_width;
  endfunction

endpackage

// File: rtl/VX_fifo_queue.sv
// Generic in-order FIFO with register storage; head is read from registered state.
// Latency: a push is visible at the head the following cycle.
// Backpressure: push while full and pop while empty are ignored; callers watch full/empty.
module VX_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_out = mem_q[rd_ptr_q];

endmodule

// File: rtl/vx_hpdcache_tid_alloc.sv
// Tid allocator: free bitmap, lowest-index priority pick, outstanding count.
// Latency: pick is combinational from the registered bitmap; alloc/free take effect next cycle.
// Backpressure: avail_o drops when every tid is held; callers gate alloc_i on it.
module vx_hpdcache_tid_alloc
  import vx_hpdcache_tid_pkg::*;
#(
  parameter int TID_WIDTH = DEF_TID_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_i,
  output logic                 avail_o,
  output logic [TID_WIDTH-1:0] alloc_tid_o,
  input  logic                 free_i,
  input  logic [TID_WIDTH-1:0] free_tid_i,
  input  logic [TID_WIDTH-1:0] query_tid_i,
  output logic                 query_busy_o,
  output logic [TID_WIDTH:0]   outstanding_o
);

  localparam int NT = num_tids(TID_WIDTH);

  logic [NT-1:0]      free_q, free_d;
  logic [TID_WIDTH:0] cnt_q, cnt_d;
  logic               do_alloc, do_free;

  // Lowest-index free tid: scan downwards so the last hit is the lowest one.
  always_comb begin
    avail_o     = 1'b0;
    alloc_tid_o = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        avail_o     = 1'b1;
        alloc_tid_o = TID_WIDTH'(i);
      end
    end
  end

  assign query_busy_o = !free_q[query_tid_i];
  assign do_alloc     = alloc_i && avail_o;
  assign do_free      = free_i && !free_q[free_tid_i];

  // Alloc and free can coincide; the freed tid is busy now, so they never collide.
  always_comb begin
    free_d = free_q;
    cnt_d  = cnt_q;
    if (do_alloc) free_d[alloc_tid_o] = 1'b0;
    if (do_free)  free_d[free_tid_i]  = 1'b1;
    case ({do_alloc, do_free})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Bitmap and count registers; reset frees every tid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= '1;
      cnt_q  <= '0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

endmodule

// File: rtl/vx_hpdcache_tid_remap.sv
// Remaps wide Vortex core tags onto narrow HPDCache tids and restores them on response.
// Latency: request path combinational; response reaches the core one cycle after the cache returns it.
// Backpressure: loads stall when no tid is free; responses queue in a FIFO that cannot overflow.
// Optional build macro VX_HPDC_TID_PERF_EN adds saturating perf_tid_stall / perf_loads counters.
module vx_hpdcache_tid_remap
  import vx_hpdcache_tid_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CORE_TAG_WIDTH = DEF_CORE_TAG_WIDTH,
  parameter int TID_WIDTH      = DEF_TID_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_req_valid,
  input  logic                      core_req_rw,
  input  logic [ADDR_WIDTH-1:0]     core_req_addr,
  input  logic [DATA_WIDTH-1:0]     core_req_data,
  input  logic [DATA_WIDTH/8-1:0]   core_req_byteen,
  input  logic [CORE_TAG_WIDTH-1:0] core_req_tag,
  output logic                      core_req_ready,
  output logic                      out_req_valid,
  output logic                      out_req_rw,
  output logic [ADDR_WIDTH-1:0]     out_req_addr,
  output logic [DATA_WIDTH-1:0]     out_req_data,
  output logic [DATA_WIDTH/8-1:0]   out_req_byteen,
  output logic [TID_WIDTH-1:0]      out_req_tid,
  input  logic                      out_req_ready,
  input  logic                      out_rsp_valid,
  input  logic [TID_WIDTH-1:0]      out_rsp_tid,
  input  logic [DATA_WIDTH-1:0]     out_rsp_data,
  output logic                      core_rsp_valid,
  output logic [DATA_WIDTH-1:0]     core_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0] core_rsp_tag,
  input  logic                      core_rsp_ready,
  output logic                      idle,
  output logic [TID_WIDTH:0]        outstanding
`ifdef VX_HPDC_TID_PERF_EN
  ,
  output logic [31:0]               perf_tid_stall,
  output logic [31:0]               perf_loads
`endif
);

  localparam int NT = num_tids(TID_WIDTH);

  typedef struct packed {
    logic [TID_WIDTH-1:0]      tid;
    logic [CORE_TAG_WIDTH-1:0] tag;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  logic                      tid_avail;
  logic [TID_WIDTH-1:0]      alloc_tid;
  logic                      alloc_fire;
  logic                      rsp_tid_busy;
  logic                      rsp_push;
  logic                      rsp_pop;
  logic                      fifo_empty;
  logic                      fifo_full;
  entry_t                    push_entry;
  entry_t                    head_entry;
  logic [CORE_TAG_WIDTH-1:0] tag_table_q [NT];

  // Stores bypass tid allocation; loads need a free tid before they can leave.
  assign out_req_valid  = core_req_valid && (core_req_rw || tid_avail);
  assign core_req_ready = out_req_ready && (core_req_rw || tid_avail);
  assign out_req_rw     = core_req_rw;
  assign out_req_addr   = core_req_addr;
  assign out_req_data   = core_req_data;
  assign out_req_byteen = core_req_byteen;
  assign out_req_tid    = core_req_rw ? '0 : alloc_tid;
  assign alloc_fire     = core_req_valid && core_req_ready && !core_req_rw;

  // A tid stays held until the core has taken its response, which caps FIFO occupancy.
  assign rsp_pop  = core_rsp_valid && core_rsp_ready;
  assign rsp_push = out_rsp_valid && rsp_tid_busy;

  vx_hpdcache_tid_alloc #(
    .TID_WIDTH (TID_WIDTH)
  ) u_alloc (
    .clk           (clk),
    .rst           (reset),
    .alloc_i       (alloc_fire),
    .avail_o       (tid_avail),
    .alloc_tid_o   (alloc_tid),
    .free_i        (rsp_pop),
    .free_tid_i    (head_entry.tid),
    .query_tid_i   (out_rsp_tid),
    .query_busy_o  (rsp_tid_busy),
    .outstanding_o (outstanding)
  );

  // Capture the core tag against the tid handed out on a load handshake.
  always_ff @(posedge clk) begin
    if (alloc_fire) tag_table_q[alloc_tid] <= core_req_tag;
  end

  assign push_entry.tid  = out_rsp_tid;
  assign push_entry.tag  = tag_table_q[out_rsp_tid];
  assign push_entry.data = out_rsp_data;

  VX_fifo_queue #(
    .DATAW ($bits(entry_t)),
    .DEPTH (NT)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rsp_push),
    .pop      (rsp_pop),
    .data_in  (push_entry),
    .data_out (head_entry),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign core_rsp_valid = !fifo_empty;
  assign core_rsp_data  = head_entry.data;
  assign core_rsp_tag   = head_entry.tag;
  assign idle           = (outstanding == '0) && fifo_empty;

  // Check response-side invariants: unknown tids are dropped, the FIFO never overflows.
  always_ff @(posedge clk) begin
    if (!reset && out_rsp_valid) begin
      assert (rsp_tid_busy)
        else $warning("vx_hpdcache_tid_remap: response for unallocated tid %0d dropped", out_rsp_tid);
      assert (!(rsp_push && fifo_full))
        else $error("vx_hpdcache_tid_remap: response FIFO overflow");
    end
  end

`ifdef VX_HPDC_TID_PERF_EN
  logic        load_stall;
  logic [31:0] perf_tid_stall_q, perf_loads_q;

  assign load_stall = core_req_valid && !core_req_rw && out_req_ready && !tid_avail;

  // Saturating counters for tid-starvation cycles and accepted loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_tid_stall_q <= '0;
      perf_loads_q     <= '0;
    end else begin
      if (load_stall && perf_tid_stall_q != 32'hFFFF_FFFF) perf_tid_stall_q <= perf_tid_stall_q + 32'd1;
      if (alloc_fire && perf_loads_q != 32'hFFFF_FFFF)     perf_loads_q     <= perf_loads_q + 32'd1;
    end
  end

  assign perf_tid_stall = perf_tid_stall_q;
  assign perf_loads     = perf_loads_q;
`endif

endmodule

// File: tb/tb_vx_hpdcache_tid_remap.sv
// Bench for vx_hpdcache_tid_remap: directed scenarios plus randomized traffic.
// A set/queue model of tids and the in-order response stream is compared every cycle.
// Responses are only issued for tids the model knows are outstanding, except the deliberate stale cases.
module tb_vx_hpdcache_tid_remap;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int IW = 3;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_req_valid = 1'b0;
  logic          core_req_rw = 1'b0;
  logic [AW-1:0] core_req_addr = '0;
  logic [DW-1:0] core_req_data = '0;
  logic [3:0]    core_req_byteen = '0;
  logic [TW-1:0] core_req_tag = '0;
  logic          core_req_ready;
  logic          out_req_valid;
  logic          out_req_rw;
  logic [AW-1:0] out_req_addr;
  logic [DW-1:0] out_req_data;
  logic [3:0]    out_req_byteen;
  logic [IW-1:0] out_req_tid;
  logic          out_req_ready = 1'b0;
  logic          out_rsp_valid = 1'b0;
  logic [IW-1:0] out_rsp_tid = '0;
  logic [DW-1:0] out_rsp_data = '0;
  logic          core_rsp_valid;
  logic [DW-1:0] core_rsp_data;
  logic [TW-1:0] core_rsp_tag;
  logic          core_rsp_ready = 1'b0;
  logic          idle;
  logic [IW:0]   outstanding;
`ifdef VX_HPDC_TID_PERF_EN
  logic [31:0]   perf_tid_stall;
  logic [31:0]   perf_loads;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  vx_hpdcache_tid_remap #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CORE_TAG_WIDTH (TW), .TID_WIDTH (IW)
  ) dut (
    .clk (clk), .reset (reset),
    .core_req_valid (core_req_valid), .core_req_rw (core_req_rw),
    .core_req_addr (core_req_addr), .core_req_data (core_req_data),
    .core_req_byteen (core_req_byteen), .core_req_tag (core_req_tag),
    .core_req_ready (core_req_ready),
    .out_req_valid (out_req_valid), .out_req_rw (out_req_rw),
    .out_req_addr (out_req_addr), .out_req_data (out_req_data),
    .out_req_byteen (out_req_byteen), .out_req_tid (out_req_tid),
    .out_req_ready (out_req_ready),
    .out_rsp_valid (out_rsp_valid), .out_rsp_tid (out_rsp_tid), .out_rsp_data (out_rsp_data),
    .core_rsp_valid (core_rsp_valid), .core_rsp_data (core_rsp_data),
    .core_rsp_tag (core_rsp_tag), .core_rsp_ready (core_rsp_ready),
    .idle (idle), .outstanding (outstanding)
`ifdef VX_HPDC_TID_PERF_EN
    , .perf_tid_stall (perf_tid_stall), .perf_loads (perf_loads)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [IW-1:0] tid;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  bit            m_busy [NT];
  logic [TW-1:0] m_tag  [NT];
  ent_t          m_q    [$];
  int            pend   [$];   // held tids that have not yet been answered

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
    m_q.delete();
    pend.delete();
  endtask

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  initial begin : compare_proc
    int   lo;
    int   cnt;
    bit   avail;
    bit   pop_ok;
    bit   push_ok;
    bit   alloc_ok;
    bit   exp_vld;
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_reset();
        chk("m_rst_rsp_valid", core_rsp_valid, 0);
        chk("m_rst_outstanding", outstanding, 0);
        chk("m_rst_idle", idle, 1);
      end else begin
        lo  = -1;
        cnt = 0;
        for (int i = NT - 1; i >= 0; i--) if (!m_busy[i]) lo = i;
        for (int i = 0; i < NT; i++) if (m_busy[i]) cnt++;
        avail   = (lo >= 0);
        exp_vld = core_req_valid && (core_req_rw || avail);
        chk("m_out_req_valid", out_req_valid, exp_vld);
        chk("m_core_req_ready", core_req_ready, out_req_ready && (core_req_rw || avail));
        if (exp_vld) begin
          chk("m_out_req_rw", out_req_rw, core_req_rw);
          chk("m_out_req_addr", out_req_addr, core_req_addr);
          chk("m_out_req_data", out_req_data, core_req_data);
          chk("m_out_req_byteen", out_req_byteen, core_req_byteen);
          chk("m_out_req_tid", out_req_tid, core_req_rw ? 0 : lo);
        end
        chk("m_core_rsp_valid", core_rsp_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          chk("m_core_rsp_tag", core_rsp_tag, m_q[0].tag);
          chk("m_core_rsp_data", core_rsp_data, m_q[0].data);
        end
        chk("m_outstanding", outstanding, cnt);
        chk("m_idle", idle, (cnt == 0) && (m_q.size() == 0));

        pop_ok   = (m_q.size() > 0) && core_rsp_ready;
        push_ok  = out_rsp_valid && m_busy[out_rsp_tid];
        alloc_ok = core_req_valid && !core_req_rw && avail && out_req_ready;
        if (push_ok) begin
          e.tid  = out_rsp_tid;
          e.tag  = m_tag[out_rsp_tid];
          e.data = out_rsp_data;
        end
        if (pop_ok) begin
          m_busy[m_q[0].tid] = 1'b0;
          void'(m_q.pop_front());
        end
        if (alloc_ok) begin
          m_busy[lo] = 1'b1;
          m_tag[lo]  = core_req_tag;
          pend.push_back(lo);
        end
        if (push_ok) m_q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    core_req_valid = 1'b0;
    out_rsp_valid  = 1'b0;
  endtask

  task automatic drive_req(input bit rw, input logic [AW-1:0] a, input logic [TW-1:0] t);
    core_req_valid  = 1'b1;
    core_req_rw     = rw;
    core_req_addr   = a;
    core_req_tag    = t;
    core_req_data   = $urandom;
    core_req_byteen = 4'($urandom);
  endtask

  task automatic send_rsp(input int tid, input logic [DW-1:0] d);
    out_rsp_valid = 1'b1;
    out_rsp_tid   = IW'(tid);
    out_rsp_data  = d;
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k] == tid) begin
        pend.delete(k);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    n_errs++;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int budget;
    out_req_ready = 1'b1;
    cyc();
    cyc();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_idle", idle, 1);
    chk("reset_rsp_valid", core_rsp_valid, 0);
    chk("reset_rsp_data", core_rsp_data, 0);
    chk("reset_rsp_tag", core_rsp_tag, 0);
    chk("reset_out_req_valid", out_req_valid, 0);
    reset = 1'b0;
    cyc();

    // Single load round trip
    drive_req(1'b0, 26'h100, 16'h1234);
    settle();
    chk("t1_out_req_valid", out_req_valid, 1);
    chk("t1_core_req_ready", core_req_ready, 1);
    chk("t1_out_req_tid", out_req_tid, 0);
    chk("t1_out_req_addr", out_req_addr, 26'h100);
    cyc();
    core_req_valid = 1'b0;
    settle();
    chk("t1_outstanding", outstanding, 1);
    chk("t1_not_idle", idle, 0);
    send_rsp(0, 32'hCAFEBABE);
    core_rsp_ready = 1'b1;
    settle();
    chk("t1_rsp_not_yet", core_rsp_valid, 0);
    cyc();
    out_rsp_valid = 1'b0;
    settle();
    chk("t1_rsp_valid", core_rsp_valid, 1);
    chk("t1_rsp_tag", core_rsp_tag, 16'h1234);
    chk("t1_rsp_data", core_rsp_data, 32'hCAFEBABE);
    cyc();
    chk("t1_rsp_done", core_rsp_valid, 0);
    chk("t1_idle", idle, 1);

    // Fill every tid, 9th load stalls, a store still passes
    core_rsp_ready = 1'b0;
    for (int i = 0; i < NT; i++) begin
      drive_req(1'b0, AW'(i), 16'h0100 + 16'(i));
      settle();
      chk("t2_tid", out_req_tid, i);
      chk("t2_ready", core_req_ready, 1);
      cyc();
    end
    drive_req(1'b0, 26'h9, 16'h0108);
    settle();
    chk("t2_ninth_ready", core_req_ready, 0);
    chk("t2_ninth_valid", out_req_valid, 0);
    chk("t2_outstanding_full", outstanding, 8);
    drive_req(1'b1, 26'h55, 16'hBEEF);
    settle();
    chk("t2_store_valid", out_req_valid, 1);
    chk("t2_store_ready", core_req_ready, 1);
    chk("t2_store_tid", out_req_tid, 0);
    cyc();
    core_req_valid = 1'b0;
    settle();
    chk("t2_outstanding_after_store", outstanding, 8);

    // Out-of-order responses 5,2,7 held back, then delivered in arrival order
    send_rsp(5, 32'h55);
    cyc();
    send_rsp(2, 32'h22);
    cyc();
    send_rsp(7, 32'h77);
    cyc();
    out_rsp_valid = 1'b0;
    repeat (10) cyc();
    chk("t3_hold_valid", core_rsp_valid, 1);
    chk("t3_head_tag", core_rsp_tag, 16'h0105);
    chk("t3_head_data", core_rsp_data, 32'h55);
    chk("t3_hold_outstanding", outstanding, 8);
    core_rsp_ready = 1'b1;
    cyc();
    chk("t3_second_tag", core_rsp_tag, 16'h0102);
    chk("t3_second_data", core_rsp_data, 32'h22);
    chk("t3_out_7", outstanding, 7);
    cyc();
    chk("t3_third_tag", core_rsp_tag, 16'h0107);
    chk("t3_out_6", outstanding, 6);
    cyc();
    chk("t3_drained", core_rsp_valid, 0);
    chk("t3_out_5", outstanding, 5);
    core_rsp_ready = 1'b0;

    // Refill freed tids lowest-first, then same-cycle free/alloc of tid 3
    drive_req(1'b0, 26'h200, 16'h0202);
    settle();
    chk("t4_tid_a", out_req_tid, 2);
    cyc();
    drive_req(1'b0, 26'h201, 16'h0205);
    settle();
    chk("t4_tid_b", out_req_tid, 5);
    cyc();
    drive_req(1'b0, 26'h202, 16'h0207);
    settle();
    chk("t4_tid_c", out_req_tid, 7);
    cyc();
    core_req_valid = 1'b0;
    send_rsp(3, 32'h33);
    cyc();
    out_rsp_valid = 1'b0;
    drive_req(1'b0, 26'h303, 16'h0303);
    core_rsp_ready = 1'b1;
    settle();
    chk("t4_rsp3_tag", core_rsp_tag, 16'h0103);
    chk("t4_same_cycle_stall", core_req_ready, 0);
    cyc();
    core_rsp_ready = 1'b0;
    settle();
    chk("t4_after_free_ready", core_req_ready, 1);
    chk("t4_after_free_tid", out_req_tid, 3);
    cyc();
    core_req_valid = 1'b0;
    settle();
    chk("t4_outstanding", outstanding, 8);

    // Free tid 6, then answer it again while unallocated
    send_rsp(6, 32'h66);
    cyc();
    out_rsp_valid  = 1'b0;
    core_rsp_ready = 1'b1;
    cyc();
    core_rsp_ready = 1'b0;
    chk("t5_freed_6", outstanding, 7);
    out_rsp_valid = 1'b1;
    out_rsp_tid   = 3'd6;
    out_rsp_data  = 32'hDEAD0006;
    cyc();
    out_rsp_valid = 1'b0;
    chk("t5_stale_no_rsp", core_rsp_valid, 0);
    chk("t5_stale_outstanding", outstanding, 7);
    cyc();
    chk("t5_stale_no_rsp_later", core_rsp_valid, 0);

    // Reset with four loads outstanding, then a stale response for tid 1
    reset = 1'b1;
    quiet();
    cyc();
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, AW'(16 + i), 16'h0400 + 16'(i));
      cyc();
    end
    core_req_valid = 1'b0;
    settle();
    chk("t6_outstanding_4", outstanding, 4);
    reset = 1'b1;
    settle();
    chk("t6_async_outstanding", outstanding, 0);
    chk("t6_async_idle", idle, 1);
    cyc();
    reset = 1'b0;
    cyc();
    out_rsp_valid = 1'b1;
    out_rsp_tid   = 3'd1;
    out_rsp_data  = 32'h11;
    cyc();
    out_rsp_valid = 1'b0;
    chk("t6_stale_no_rsp", core_rsp_valid, 0);
    chk("t6_outstanding", outstanding, 0);
    chk("t6_idle", idle, 1);

    // Randomized traffic, with one reset dropped into the middle
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (n == 1500) begin
        reset = 1'b1;
        quiet();
        continue;
      end
      reset           = 1'b0;
      core_req_valid  = ($urandom_range(0, 99) < 60);
      core_req_rw     = ($urandom_range(0, 3) == 0);
      core_req_addr   = AW'($urandom);
      core_req_data   = $urandom;
      core_req_byteen = 4'($urandom);
      core_req_tag    = TW'($urandom);
      out_req_ready   = ($urandom_range(0, 9) < 8);
      core_rsp_ready  = ($urandom_range(0, 9) < 6);
      if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
        int idx;
        idx = $urandom_range(0, pend.size() - 1);
        send_rsp(pend[idx], $urandom);
      end else begin
        out_rsp_valid = 1'b0;
        out_rsp_tid   = '0;
      end
    end

    // Drain everything outstanding
    core_req_valid = 1'b0;
    core_rsp_ready = 1'b1;
    budget = 0;
    while (pend.size() > 0 && budget < 200) begin
      cyc();
      send_rsp(pend[0], $urandom);
      budget++;
    end
    cyc();
    out_rsp_valid = 1'b0;
    budget = 0;
    while (!idle && budget < 50) begin
      cyc();
      budget++;
    end
    chk("drain_idle", idle, 1);
    chk("drain_outstanding", outstanding, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
